// File: rtl/bus_write_arbiter_if.sv
// bus_write_arbiter_if: per-core write ports and the shared slave write port of the arbiter.
interface bus_write_arbiter_if #(
    parameter int NUM_CORES    = 8,
    parameter int LANES        = 6,
    parameter int DATA_W       = 32,
    parameter int SLAVE_ADDR_W = 6
);
    localparam int ID_W          = $clog2(NUM_CORES);
    localparam int MASTER_ADDR_W = SLAVE_ADDR_W + ID_W;
    logic [NUM_CORES-1:0]                   s_wvalid;
    logic [NUM_CORES-1:0]                   s_wready;
    logic [NUM_CORES-1:0]                   s_wlast;
    logic [NUM_CORES-1:0][LANES*DATA_W-1:0] s_wdata;
    logic [NUM_CORES-1:0][SLAVE_ADDR_W-1:0] s_waddr;
    logic                                   m_wvalid;
    logic                                   m_wready;
    logic [LANES*DATA_W-1:0]                m_wdata;
    logic [MASTER_ADDR_W-1:0]               m_waddr;
    logic [ID_W-1:0]                        m_wid;
    // master: the arbiter, mastering the shared slave port
    modport master (
        input  s_wvalid, s_wlast, s_wdata, s_waddr, m_wready,
        output s_wready, m_wvalid, m_wdata, m_waddr, m_wid
    );
    modport slave (
        output s_wvalid, s_wlast, s_wdata, s_waddr, m_wready,
        input  s_wready, m_wvalid, m_wdata, m_waddr, m_wid
    );
endinterface

// File: rtl/bus_write_arbiter.sv
// bus_write_arbiter: round-robin N-core write arbiter with a registered output stage.
// Define ARB_BURST_LOCK_EN to hold the grant on one core until its s_wlast beat.
module bus_write_arbiter #(
    parameter int NUM_CORES    = 8,
    parameter int LANES        = 6,
    parameter int DATA_W       = 32,
    parameter int SLAVE_ADDR_W = 6
) (
    input logic                 clk,
    input logic                 rst_n,
    bus_write_arbiter_if.master bus
);
    localparam int ID_W          = $clog2(NUM_CORES);
    localparam int MASTER_ADDR_W = SLAVE_ADDR_W + ID_W;

    logic                     r_valid;
    logic [LANES*DATA_W-1:0]  r_data;
    logic [MASTER_ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]          r_last;
    logic                     w_load;
    logic                     w_any;
    logic [ID_W-1:0]          w_gid;
    logic [ID_W-1:0]          w_idx;
    logic [NUM_CORES-1:0]     w_req;
    logic [NUM_CORES-1:0]     w_grant;

`ifdef ARB_BURST_LOCK_EN
    logic            r_lock;
    logic [ID_W-1:0] r_lock_id;
    assign w_req = r_lock ? (bus.s_wvalid & (NUM_CORES'(1) << r_lock_id)) : bus.s_wvalid;
`else
    logic w_unused_wlast;
    assign w_unused_wlast = ^bus.s_wlast;
    assign w_req          = bus.s_wvalid;
`endif

    // Scan from lowest to highest priority so the nearest requester after r_last wins.
    always_comb begin
        w_any = 1'b0;
        w_gid = '0;
        w_idx = '0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last) + k) % NUM_CORES);
            if (w_req[w_idx]) begin
                w_any = 1'b1;
                w_gid = w_idx;
            end
        end
    end

    assign w_grant      = w_any ? (NUM_CORES'(1) << w_gid) : '0;
    assign w_load       = !r_valid || bus.m_wready;
    assign bus.s_wready = (rst_n && w_load) ? w_grant : '0;
    assign bus.m_wvalid = r_valid;
    assign bus.m_wdata  = r_data;
    assign bus.m_waddr  = r_addr;
    assign bus.m_wid    = r_addr[SLAVE_ADDR_W +: ID_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_last  <= ID_W'(NUM_CORES - 1);
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= bus.s_wdata[w_gid];
                r_addr <= {w_gid, bus.s_waddr[w_gid]};
                r_last <= w_gid;
            end
        end
    end

`ifdef ARB_BURST_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_load && w_any) begin
            r_lock    <= !bus.s_wlast[w_gid];
            r_lock_id <= w_gid;
        end
    end
`endif
endmodule

// File: tb/tb_bus_write_arbiter.sv
// tb_bus_write_arbiter: directed vector table plus reset sequences for bus_write_arbiter.
module tb_bus_write_arbiter;
    localparam int N  = 8;
    localparam int L  = 6;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int IW = 3;

    typedef struct {
        logic [N-1:0]  v;
        logic [N-1:0]  wl;
        logic          rdy;
        logic [N-1:0]  e_rdy;
        logic          e_mv;
        logic [IW-1:0] e_id;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    bus_write_arbiter_if #(.NUM_CORES(N), .LANES(L), .DATA_W(DW), .SLAVE_ADDR_W(AW)) bus ();
    bus_write_arbiter #(.NUM_CORES(N), .LANES(L), .DATA_W(DW), .SLAVE_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    function automatic logic [L*DW-1:0] data_of(int i);
        data_of = '0;
        for (int l = 0; l < L; l++) data_of[l*DW +: DW] = 32'hA500_0000 + 32'(i * 16 + l);
    endfunction

    function automatic logic [AW-1:0] addr_of(int i);
        return (i == 5) ? 6'h2A : 6'(i * 7);
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(logic [N-1:0] v, logic [N-1:0] wl, logic rdy, logic [N-1:0] e_rdy,
                       logic e_mv, logic [IW-1:0] e_id);
        vecs.push_back(vec_t'{v, wl, rdy, e_rdy, e_mv, e_id});
    endtask

    task automatic chk_out(string tag, logic e_mv, logic [IW-1:0] e_id);
        chk({tag, " m_wvalid"}, 256'(bus.m_wvalid), 256'(e_mv));
        chk({tag, " m_wid"}, 256'(bus.m_wid), 256'(e_id));
        chk({tag, " m_waddr"}, 256'(bus.m_waddr), 256'({e_id, addr_of(int'(e_id))}));
        chk({tag, " m_wdata"}, 256'(bus.m_wdata), 256'(data_of(int'(e_id))));
    endtask

    initial begin
        // round robin: all cores valid, ids 0..7 twice
        for (int i = 0; i < 16; i++) add(8'hFF, 8'hFF, 1'b1, 8'(1 << (i % 8)), 1'b1, 3'(i % 8));
        // sparse/wrap from last_grant=7, then single requester
        add(8'h40, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6);
        add(8'h42, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1);
        add(8'h42, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6);
        add(8'h42, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1);
        add(8'h42, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6);
        for (int i = 0; i < 3; i++) add(8'h04, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2);
        add(8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd2);
        // backpressure: core 3 beat held 4 cycles, core 4 accepted as it drains
        add(8'h08, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3);
        for (int i = 0; i < 4; i++) add(8'h18, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3);
        add(8'h18, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4);
        add(8'h08, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3);
        // core 4 burst of 3 with a 2-cycle gap while core 0 requests
`ifdef ARB_BURST_LOCK_EN
        add(8'h11, 8'hEF, 1'b1, 8'h10, 1'b1, 3'd4);
        add(8'h01, 8'hEF, 1'b1, 8'h00, 1'b0, 3'd4);
        add(8'h01, 8'hEF, 1'b1, 8'h00, 1'b0, 3'd4);
        add(8'h11, 8'hEF, 1'b1, 8'h10, 1'b1, 3'd4);
        add(8'h11, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4);
        add(8'h01, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0);
`else
        add(8'h11, 8'hEF, 1'b1, 8'h10, 1'b1, 3'd4);
        add(8'h01, 8'hEF, 1'b1, 8'h01, 1'b1, 3'd0);
        add(8'h01, 8'hEF, 1'b1, 8'h01, 1'b1, 3'd0);
        add(8'h11, 8'hEF, 1'b1, 8'h10, 1'b1, 3'd4);
        add(8'h11, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0);
        add(8'h01, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0);
`endif

        for (int i = 0; i < N; i++) begin
            bus.s_wdata[3'(i)] = data_of(i);
            bus.s_waddr[3'(i)] = addr_of(i);
        end
        bus.s_wvalid = 8'hFF;
        bus.s_wlast  = 8'hFF;
        bus.m_wready = 1'b1;
        #12;
        chk("reset s_wready", 256'(bus.s_wready), 256'(0));
        chk("reset m_wvalid", 256'(bus.m_wvalid), 256'(0));
        chk("reset m_wdata", 256'(bus.m_wdata), 256'(0));
        chk("reset m_waddr", 256'(bus.m_waddr), 256'(0));
        chk("reset m_wid", 256'(bus.m_wid), 256'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.s_wvalid = vecs[i].v;
            bus.s_wlast  = vecs[i].wl;
            bus.m_wready = vecs[i].rdy;
            #1 chk($sformatf("row%0d s_wready", i), 256'(bus.s_wready), 256'(vecs[i].e_rdy));
            @(posedge clk);
            #1 chk_out($sformatf("row%0d", i), vecs[i].e_mv, vecs[i].e_id);
        end

        // reset while a beat is held under backpressure
        @(negedge clk);
        bus.s_wvalid = 8'h02;
        bus.m_wready = 1'b1;
        @(posedge clk);
        #1 chk_out("midrst load", 1'b1, 3'd1);
        @(negedge clk);
        bus.s_wvalid = 8'hFF;
        bus.m_wready = 1'b0;
        #1 chk("midrst stall s_wready", 256'(bus.s_wready), 256'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst m_wvalid", 256'(bus.m_wvalid), 256'(0));
        chk("midrst m_wdata", 256'(bus.m_wdata), 256'(0));
        chk("midrst m_waddr", 256'(bus.m_waddr), 256'(0));
        chk("midrst s_wready", 256'(bus.s_wready), 256'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1 chk("postrst s_wready", 256'(bus.s_wready), 256'(1));
        @(posedge clk);
        #1 chk_out("postrst", 1'b1, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
